// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front-end: opcodes, FSM states,
// qualified-flag bundle and default data widths.
package alu_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OPW_DEF   = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_CMP = 3'b110;
  localparam logic [2:0] ALU_EQU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_flag_qual.sv
// Flag qualification: carry/overflow are only meaningful for add/sub, so
// they are masked for every other opcode; zero is recomputed from the data.
module alu_flag_qual
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output flags_t           flags
);

  logic is_arith;

  // Arithmetic ops pass carry/overflow through, everything else forces 0
  always_comb begin
    is_arith       = (op == OPW'(ALU_ADD)) || (op == OPW'(ALU_SUB));
    flags.carry    = is_arith & alu_carry;
    flags.overflow = is_arith & alu_overflow;
    flags.zero     = (alu_out == '0);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command front-end for the 4-bit combinational ALU: accepts commands,
// drives registered operands into the ALU, captures the result and flags,
// and hands them downstream. Keeps an accumulator of the last result.
// Optional: define ALU_ISSUE_PERF_EN to add the 16-bit op_count output.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic [OPW-1:0]   alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_overflow
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [15:0]      op_count
`endif
);

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic             accept;
  flags_t           qflags;

  // Zero is recomputed locally from the captured data
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  alu_flag_qual #(.WIDTH(WIDTH), .OPW(OPW)) u_flag_qual (
    .op           (alu_sel),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .flags        (qflags)
  );

  // Ready in IDLE, or in DONE when the pending result is consumed this cycle;
  // a same-cycle acc_clr makes a use_acc command see zero
  always_comb begin
    cmd_ready = (state == IDLE) || ((state == DONE) && res_ready);
    accept    = cmd_valid && cmd_ready;
    op_a      = cmd_use_acc ? (acc_clr ? '0 : acc) : cmd_a;
  end

  // Issue FSM: latch operands, capture ALU result, hold it until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      alu_sel      <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      acc          <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_carry    <= 1'b0;
      res_zero     <= 1'b0;
      res_overflow <= 1'b0;
    end else begin
      // Clear first so the EXEC capture below overrides it
      if (acc_clr) acc <= '0;
      if (accept) begin
        alu_sel <= cmd_op;
        alu_a   <= op_a;
        alu_b   <= cmd_b;
      end
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          res_data     <= alu_out;
          res_carry    <= qflags.carry;
          res_zero     <= qflags.zero;
          res_overflow <= qflags.overflow;
          acc          <= alu_out;
          res_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= accept ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // Count consumed results; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= '0;
    else if (res_valid && res_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with a transaction-level reference
// model and a behavioural ALU stub that forces carry/overflow high on
// non-arithmetic ops.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_use_acc, acc_clr;
  logic [2:0] cmd_op, alu_sel;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, res_data;
  logic       alu_carry, alu_zero, alu_overflow;
  logic       res_valid, res_ready, res_carry, res_zero, res_overflow;
  logic       stub_force = 1'b1;
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] op_count;
`endif

  int errs   = 0;
  int checks = 0;

  // reference model state
  logic [3:0] m_acc;
  logic       in_done;
  int         m_cnt;
  logic [3:0] e_data;
  logic       e_c, e_z, e_v;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_overflow(res_overflow)
`ifdef ALU_ISSUE_PERF_EN
    , .op_count(op_count)
`endif
  );

  // Returns {out[3:0], carry, overflow} for the 4-bit ALU
  function automatic logic [5:0] alu_ref(input logic [2:0] op,
                                          input logic [3:0] a, input logic [3:0] b);
    int s;
    logic [3:0] o;
    logic c, v;
    c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); o = s[3:0]; c = s > 15;
                  v = (a[3] == b[3]) && (o[3] != a[3]); end
      3'd1: begin s = int'(a) - int'(b); o = s[3:0]; c = s >= 0;
                  v = (a[3] != b[3]) && (o[3] != a[3]); end
      3'd2: o = ~a;
      3'd3: o = a & b;
      3'd4: o = a | b;
      3'd5: o = a ^ b;
      3'd6: o = (a > b) ? 4'd1 : 4'd0;
      default: o = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {o, c, v};
  endfunction

  // ALU stub: non-arithmetic ops get carry/overflow forced so masking is visible
  always_comb begin
    {alu_out, alu_carry, alu_overflow} = alu_ref(alu_sel, alu_a, alu_b);
    if (alu_sel > 3'd1) begin
      alu_carry    = stub_force;
      alu_overflow = stub_force;
    end
    alu_zero = (alu_out == 4'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_res(input string tag);
    chk({tag, ".valid"}, res_valid, 1);
    chk({tag, ".data"},  res_data,  e_data);
    chk({tag, ".carry"}, res_carry, e_c);
    chk({tag, ".zero"},  res_zero,  e_z);
    chk({tag, ".ovf"},   res_overflow, e_v);
  endtask

  // Issue one command (consuming any pending result the same cycle),
  // check the EXEC cycle, the result 2 cycles later, then stall.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic use_acc, input logic clr, input int stall);
    logic [3:0] ae;
    logic [5:0] r;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; acc_clr = clr;
    cmd_valid = 1'b1; res_ready = 1'b1;
    #1;
    chk("accept.ready", cmd_ready, 1);
    if (in_done) m_cnt++;
    ae = use_acc ? (clr ? 4'd0 : m_acc) : a;
    r  = alu_ref(op, ae, b);
    @(posedge clk); #1;
    cmd_valid = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;
    cmd_a = $urandom; cmd_b = $urandom; cmd_op = $urandom; cmd_use_acc = $urandom;
    chk("exec.sel", alu_sel, op);
    chk("exec.a",   alu_a,   ae);
    chk("exec.b",   alu_b,   b);
    chk("exec.ready", cmd_ready, 0);
    chk("exec.valid", res_valid, 0);
    @(posedge clk); #1;
    e_data = r[5:2];
    e_c    = (op <= 3'd1) ? r[1] : 1'b0;
    e_v    = (op <= 3'd1) ? r[0] : 1'b0;
    e_z    = (r[5:2] == 4'd0);
    m_acc  = r[5:2];
    in_done = 1'b1;
    chk_res("res");
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk_res("hold");
      chk("hold.ready", cmd_ready, 0);
      chk("hold.alu_a", alu_a, ae);
    end
  endtask

  // Consume the pending result with no new command
  task automatic drain();
    cmd_valid = 1'b0; res_ready = 1'b1;
    if (in_done) m_cnt++;
    @(posedge clk); #1;
    res_ready = 1'b0;
    in_done = 1'b0;
    chk("drain.valid", res_valid, 0);
    chk("drain.ready", cmd_ready, 1);
  endtask

  // Standalone accumulator clear, pending result (if any) left untouched
  task automatic clr_pulse();
    cmd_valid = 1'b0; res_ready = 1'b0; acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    m_acc = 4'd0;
    chk("clr.valid", res_valid, in_done);
    if (in_done) chk_res("clr.hold");
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0; acc_clr = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
    m_acc = '0; in_done = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", res_valid, 0);
    chk("rst.ready", cmd_ready, 1);
    chk("rst.data",  res_data,  0);
    chk("rst.zero",  res_zero,  0);
    chk("rst.sel",   {alu_sel, alu_a, alu_b}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // add with signed overflow
    issue(ALU_ADD, 4'd4, 4'd4, 1'b0, 1'b0, 0);
    chk("add.data", res_data, 4'd8);
    chk("add.ovf",  res_overflow, 1);
    drain();
    // logic op, stub forces carry/overflow high
    issue(ALU_AND, 4'hC, 4'hA, 1'b0, 1'b0, 0);
    chk("and.data", res_data, 4'h8);
    chk("and.carry", res_carry, 0);
    drain();
    // accumulator chain, back-to-back
    issue(ALU_ADD, 4'd1, 4'd2, 1'b0, 1'b0, 0);
    issue(ALU_ADD, 4'd0, 4'd5, 1'b1, 1'b0, 0);
    chk("chain.data", res_data, 4'd8);
    drain();
    clr_pulse();
    issue(ALU_ADD, 4'd9, 4'd0, 1'b1, 1'b0, 0);
    chk("clr.data", res_data, 4'd0);
    chk("clr.zero", res_zero, 1);
    // backpressure then release with a new command in the same cycle
    issue(ALU_SUB, 4'd3, 4'd7, 1'b0, 1'b0, 5);
    issue(ALU_EQU, 4'd5, 4'd5, 1'b0, 1'b0, 0);
    chk("equ.data", res_data, 4'd1);
    chk("equ.zero", res_zero, 0);
    issue(ALU_EQU, 4'd5, 4'd6, 1'b0, 1'b0, 0);
    chk("neq.data", res_data, 4'd0);
    chk("neq.zero", res_zero, 1);
    // acc_clr alongside a use_acc command
    issue(ALU_OR, 4'd0, 4'd6, 1'b1, 1'b1, 1);
    chk("clracc.data", res_data, 4'd6);
    drain();

    // reset while in EXEC
    cmd_op = ALU_ADD; cmd_a = 4'd7; cmd_b = 4'd7; cmd_use_acc = 1'b0;
    cmd_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk("mrst.valid", res_valid, 0);
    chk("mrst.alu_a", alu_a, 0);
    m_acc = 4'd0; in_done = 1'b0; m_cnt = 0;
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst.ready", cmd_ready, 1);
    issue(ALU_ADD, 4'd0, 4'd3, 1'b1, 1'b0, 0);
    chk("mrst.acc0", res_data, 4'd3);
    drain();
    issue(ALU_ADD, 4'd2, 4'd3, 1'b0, 1'b0, 0);
    chk("mrst.add", res_data, 4'd5);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      int pick;
      pick = $urandom_range(0, 9);
      if (pick < 6)
        issue(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      else if (pick < 8 && in_done)
        drain();
      else
        clr_pulse();
    end
    if (in_done) drain();

`ifdef ALU_ISSUE_PERF_EN
    chk("op_count", op_count, 16'(m_cnt));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
